// File: rtl/regfile_sequencer.sv
// Command-driven master for an external 8 x 32 register file: optional
// post-reset clearing walk, then one load/ALU/read operation per accepted command.
module regfile_sequencer #(
    parameter bit          INIT_CLEAR = 1'b1,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        cr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_ra,
    input  logic [2:0]  cmd_rb,
    input  logic [31:0] cmd_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic [2:0]  Addr_A,
    output logic [2:0]  Addr_B,
    input  logic [31:0] QA,
    input  logic [31:0] QB,
    output logic        WE,
    output logic [2:0]  Addr_W,
    output logic [31:0] Di
);

    // state | meaning
    // INIT  | writing INIT_VALUE to r0..r7, one register per cycle
    // IDLE  | cmd_ready high, waiting for a command
    // READ  | QA/QB valid for latched ra/rb; result captured at the edge
    // WB    | WE high, register file captures Di at the end of the cycle
    // RSP   | response held until rsp_ready
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_WB, S_RSP} state_t;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_RD  = 3'd7;

    state_t      state, state_nxt;
    logic [2:0]  init_cnt, init_cnt_nxt;
    logic [2:0]  op_q, op_nxt;
    logic [2:0]  rd_q, rd_nxt;
    logic [31:0] imm_q, imm_nxt;

    logic        cmd_ready_nxt, rsp_valid_nxt, rsp_carry_nxt, we_nxt;
    logic [31:0] rsp_data_nxt, di_nxt;
    logic [2:0]  addr_a_nxt, addr_b_nxt, addr_w_nxt;

    logic [32:0] sum_add, sum_sub;
    logic [31:0] alu_res;
    logic        alu_carry;

    // SUB carry is NOT borrow, taken from QA + ~QB + 1.
    always_comb begin
        sum_add   = {1'b0, QA} + {1'b0, QB};
        sum_sub   = {1'b0, QA} + {1'b0, ~QB} + 33'd1;
        alu_res   = QA;
        alu_carry = 1'b0;
        case (op_q)
            OP_LDI:  alu_res = imm_q;
            OP_ADD:  begin alu_res = sum_add[31:0]; alu_carry = sum_add[32]; end
            OP_SUB:  begin alu_res = sum_sub[31:0]; alu_carry = sum_sub[32]; end
            OP_AND:  alu_res = QA & QB;
            OP_OR:   alu_res = QA | QB;
            OP_XOR:  alu_res = QA ^ QB;
            default: alu_res = QA;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        op_nxt        = op_q;
        rd_nxt        = rd_q;
        imm_nxt       = imm_q;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_carry_nxt = rsp_carry;
        addr_a_nxt    = Addr_A;
        addr_b_nxt    = Addr_B;
        addr_w_nxt    = Addr_W;
        di_nxt        = Di;
        we_nxt        = 1'b0;

        case (state)
            S_INIT: begin
                // Down-counter from 7; its complement gives ascending addresses.
                we_nxt     = 1'b1;
                addr_w_nxt = ~init_cnt;
                di_nxt     = INIT_VALUE;
                if (init_cnt == 3'd0) state_nxt = S_IDLE;
                else                  init_cnt_nxt = init_cnt - 3'd1;
            end
            S_IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    op_nxt        = cmd_op;
                    rd_nxt        = cmd_rd;
                    imm_nxt       = cmd_imm;
                    addr_a_nxt    = cmd_ra;
                    addr_b_nxt    = cmd_rb;
                    cmd_ready_nxt = 1'b0;
                    state_nxt     = S_READ;
                end
            end
            S_READ: begin
                di_nxt        = alu_res;
                rsp_data_nxt  = alu_res;
                rsp_carry_nxt = alu_carry;
                if (op_q == OP_RD) begin
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RSP;
                end else begin
                    we_nxt     = 1'b1;
                    addr_w_nxt = rd_q;
                    state_nxt  = S_WB;
                end
            end
            S_WB: begin
                rsp_valid_nxt = 1'b1;
                state_nxt     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cr) begin
            state     <= INIT_CLEAR ? S_INIT : S_IDLE;
            init_cnt  <= 3'd7;
            op_q      <= 3'd0;
            rd_q      <= 3'd0;
            imm_q     <= 32'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_carry <= 1'b0;
            Addr_A    <= 3'd0;
            Addr_B    <= 3'd0;
            Addr_W    <= 3'd0;
            Di        <= 32'd0;
            WE        <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            op_q      <= op_nxt;
            rd_q      <= rd_nxt;
            imm_q     <= imm_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_carry <= rsp_carry_nxt;
            Addr_A    <= addr_a_nxt;
            Addr_B    <= addr_b_nxt;
            Addr_W    <= addr_w_nxt;
            Di        <= di_nxt;
            WE        <= we_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file on the DUT's ports plus
// a reference model of register contents and operation results.
module tb_regfile_sequencer;

    localparam logic [31:0] INIT_VAL = 32'hA5A5_A5A5;
    localparam logic [2:0] OP_LDI = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_RD = 3'd7;

    logic        clk = 1'b0;
    logic        cr, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_carry, WE;
    logic [2:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb, Addr_A, Addr_B, Addr_W;
    logic [31:0] cmd_imm, rsp_data, QA, QB, Di;

    logic [31:0] rf   [8];
    logic [31:0] m_rf [8];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_count = 0;

    regfile_sequencer #(.INIT_CLEAR(1'b1), .INIT_VALUE(INIT_VAL)) dut (
        .clk(clk), .cr(cr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .Addr_A(Addr_A), .Addr_B(Addr_B), .QA(QA), .QB(QB),
        .WE(WE), .Addr_W(Addr_W), .Di(Di)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (WE === 1'b1) begin
            we_count   <= we_count + 1;
            rf[Addr_W] <= Di;
        end
    end

    assign QA = rf[Addr_A];
    assign QB = rf[Addr_B];

    // Result {carry, data} straight from the operation definitions.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, b, imm);
        logic [63:0] wide;
        case (op)
            OP_LDI: return {1'b0, imm};
            OP_ADD: begin
                wide = 64'(a) + 64'(b);
                return {(wide > 64'hFFFF_FFFF), wide[31:0]};
            end
            OP_SUB: return {(a >= b), a - b};
            OP_AND: return {1'b0, a & b};
            OP_OR:  return {1'b0, a | b};
            OP_XOR: return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    task automatic exec_model(input logic [2:0] op, rd, ra, rb, input logic [31:0] imm,
                              output logic [31:0] d, output logic c);
        logic [32:0] r;
        r = model(op, m_rf[ra], m_rf[rb], imm);
        d = r[31:0];
        c = r[32];
        if (op != OP_RD) m_rf[rd] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, waits for its response, consumes it; ok=0 on timeout.
    task automatic run_cmd(input logic [2:0] op, rd, ra, rb, input logic [31:0] imm,
                           output logic [31:0] data, output logic carry, output bit ok);
        int n;
        ok = 1'b1;
        data = 32'd0;
        carry = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (cmd_ready !== 1'b1) begin ok = 1'b0; return; end
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin step(); n++; end
        if (rsp_valid !== 1'b1) begin ok = 1'b0; return; end
        data = rsp_data;
        carry = rsp_carry;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        cr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_rd = 3'd0; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_imm = 32'd0;
        repeat (3) step();
        checks++;
        if ({WE, cmd_ready, rsp_valid, rsp_carry} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got WE/rdy/vld/c=%b%b%b%b want 0000", WE, cmd_ready, rsp_valid, rsp_carry);
        end
        checks++;
        if ({Addr_A, Addr_B, Addr_W, Di, rsp_data} !== 73'd0) begin
            errors++;
            $display("FAIL reset_data got A=%0d B=%0d W=%0d Di=%h rsp=%h want all 0", Addr_A, Addr_B, Addr_W, Di, rsp_data);
        end
        cr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (WE !== 1'b1 || Addr_W !== 3'(i) || Di !== INIT_VAL || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_walk[%0d] got WE=%b W=%0d Di=%h rdy=%b want WE=1 W=%0d Di=%h rdy=0",
                         i, WE, Addr_W, Di, cmd_ready, i, INIT_VAL);
            end
        end
        step();
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL init_end_we got %b want 0", WE);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5) begin step(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready got %b want 1 within 5 cycles", cmd_ready);
        end
        for (int i = 0; i < 8; i++) m_rf[i] = INIT_VAL;
    endtask

    task automatic test_init_read();
        logic [31:0] d, ed;
        logic c, ec;
        bit ok;
        for (int r = 0; r < 8; r++) begin
            run_cmd(OP_RD, 3'd0, 3'(r), 3'd0, 32'd0, d, c, ok);
            exec_model(OP_RD, 3'd0, 3'(r), 3'd0, 32'd0, ed, ec);
            checks++;
            if (!ok || d !== INIT_VAL || c !== 1'b0) begin
                errors++;
                $display("FAIL init_read r%0d got %h/%b ok=%0d want %h/0", r, d, c, ok, INIT_VAL);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] d, ed;
        logic c, ec;
        bit ok;
        run_cmd(OP_LDI, 3'd3, 3'd0, 3'd0, 32'h0000_0010, d, c, ok); exec_model(OP_LDI, 3'd3, 3'd0, 3'd0, 32'h10, ed, ec);
        run_cmd(OP_LDI, 3'd4, 3'd0, 3'd0, 32'h0000_0005, d, c, ok); exec_model(OP_LDI, 3'd4, 3'd0, 3'd0, 32'h5, ed, ec);
        checks++;
        if (!ok || d !== 32'h5 || c !== 1'b0) begin
            errors++;
            $display("FAIL ldi_rsp got %h/%b ok=%0d want 00000005/0", d, c, ok);
        end
        run_cmd(OP_SUB, 3'd5, 3'd3, 3'd4, 32'd0, d, c, ok); exec_model(OP_SUB, 3'd5, 3'd3, 3'd4, 32'd0, ed, ec);
        checks++;
        if (!ok || d !== 32'h0000_000B || c !== 1'b1) begin
            errors++;
            $display("FAIL sub got %h/%b ok=%0d want 0000000b/1", d, c, ok);
        end
        run_cmd(OP_RD, 3'd0, 3'd5, 3'd0, 32'd0, d, c, ok);
        checks++;
        if (!ok || d !== 32'h0000_000B) begin
            errors++;
            $display("FAIL rd_r5 got %h ok=%0d want 0000000b", d, ok);
        end
    endtask

    task automatic test_add_wrap();
        logic [31:0] d, ed;
        logic c, ec;
        bit ok;
        run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, d, c, ok); exec_model(OP_LDI, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, ed, ec);
        run_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 32'h1, d, c, ok);         exec_model(OP_LDI, 3'd2, 3'd0, 3'd0, 32'h1, ed, ec);
        run_cmd(OP_ADD, 3'd6, 3'd1, 3'd2, 32'd0, d, c, ok);         exec_model(OP_ADD, 3'd6, 3'd1, 3'd2, 32'd0, ed, ec);
        checks++;
        if (!ok || d !== 32'h0 || c !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got %h/%b ok=%0d want 00000000/1", d, c, ok);
        end
        run_cmd(OP_ADD, 3'd1, 3'd1, 3'd1, 32'd0, d, c, ok);         exec_model(OP_ADD, 3'd1, 3'd1, 3'd1, 32'd0, ed, ec);
        checks++;
        if (!ok || d !== 32'hFFFF_FFFE || c !== 1'b1) begin
            errors++;
            $display("FAIL add_self got %h/%b ok=%0d want fffffffe/1", d, c, ok);
        end
        run_cmd(OP_RD, 3'd0, 3'd1, 3'd0, 32'd0, d, c, ok);
        checks++;
        if (!ok || d !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL rd_r1 got %h ok=%0d want fffffffe", d, ok);
        end
    endtask

    task automatic test_stall();
        logic [31:0] imm, ed;
        logic ec;
        int n;
        imm = $urandom;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
        cmd_op = OP_LDI; cmd_rd = 3'd0; cmd_ra = 3'd2; cmd_rb = 3'd3; cmd_imm = imm;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        exec_model(OP_LDI, 3'd0, 3'd2, 3'd3, imm, ed, ec);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ed || cmd_ready !== 1'b0 || WE !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] got vld=%b data=%h rdy=%b WE=%b want 1/%h/0/0",
                         i, rsp_valid, rsp_data, cmd_ready, WE, ed);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got rdy=%b vld=%b want 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] d;
        logic c;
        bit ok;
        int n, we0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
        cmd_op = OP_LDI; cmd_rd = 3'd7; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_imm = 32'h1234_5678;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (WE !== 1'b1 || Addr_W !== 3'd7) begin
            errors++;
            $display("FAIL wb_reached got WE=%b W=%0d want 1/7", WE, Addr_W);
        end
        cr = 1'b0;
        step();
        checks++;
        if (WE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got WE=%b vld=%b rdy=%b want 0/0/0", WE, rsp_valid, cmd_ready);
        end
        cr = 1'b1;
        we0 = we_count;
        repeat (12) step();
        checks++;
        if (we_count - we0 != 8) begin
            errors++;
            $display("FAIL rewalk_we got %0d pulses want 8", we_count - we0);
        end
        for (int i = 0; i < 8; i++) m_rf[i] = INIT_VAL;
        run_cmd(OP_RD, 3'd0, 3'd7, 3'd0, 32'd0, d, c, ok);
        checks++;
        if (!ok || d !== INIT_VAL) begin
            errors++;
            $display("FAIL rd_r7_after_reset got %h ok=%0d want %h", d, ok, INIT_VAL);
        end
    endtask

    // Back-to-back commands with rsp_ready held high; gap must be 4 cycles (3 for RD).
    task automatic test_back_to_back(input bit rd_only, input int count);
        logic [2:0]  op, rd, ra, rb;
        logic [31:0] imm, ed;
        logic        ec;
        int n, acc, prev_acc, we0, gap;
        gap = rd_only ? 3 : 4;
        rsp_ready = 1'b1;
        we0 = we_count;
        prev_acc = 0;
        for (int i = 0; i < count; i++) begin
            op  = rd_only ? OP_RD : 3'($urandom_range(0, 6));
            rd  = 3'($urandom_range(0, 7));
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            imm = $urandom;
            cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
            cmd_valid = 1'b1;
            n = 0;
            while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b want 1 within 20 cycles", i, cmd_ready);
                break;
            end
            step();
            acc = cyc;
            exec_model(op, rd, ra, rb, imm, ed, ec);
            if (i > 0) begin
                checks++;
                if (acc - prev_acc != gap) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d] got %0d cycles want %0d", i, acc - prev_acc, gap);
                end
            end
            prev_acc = acc;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_carry !== ec) begin
                errors++;
                $display("FAIL b2b_rsp[%0d] op=%0d got vld=%b %h/%b want 1 %h/%b",
                         i, op, rsp_valid, rsp_data, rsp_carry, ed, ec);
            end
        end
        cmd_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (we_count - we0 != (rd_only ? 0 : count)) begin
            errors++;
            $display("FAIL b2b_we got %0d pulses want %0d", we_count - we0, rd_only ? 0 : count);
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_sub();
        test_add_wrap();
        test_stall();
        test_reset_mid_wb();
        test_back_to_back(1'b0, 24);
        test_back_to_back(1'b1, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
